// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;  // lowercase b
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;  // lowercase d
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph decode.
module hex_to_seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the hex glyph set
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with PWM brightness and
// frame-synchronous (tear-free) double-buffered data loading.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [4*N_DIGITS-1:0]         data,
  input  logic [N_DIGITS-1:0]           dp,
  input  logic [N_DIGITS-1:0]           digit_en,
  input  logic [3:0]                    brightness,
  output logic [N_DIGITS-1:0]           anode,
  output logic [6:0]                    seg,
  output logic                          dp_n,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
  output logic                          frame_done,
  output logic                          load_ack
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int STEP = REFRESH_DIV / 16;
  localparam int SW   = (STEP > 1) ? $clog2(STEP) : 1;

  // The prescaler is kept split as {phase, sub}: phase is the prescaler
  // divided by STEP, so no divider is needed and the slot terminal is
  // phase==15 with sub at its last count.
  logic [SW-1:0] sub;
  logic [3:0]    phase;
  logic          sub_term, slot_term, frame_bnd;

  logic                         pending;
  logic [N_DIGITS-1:0][3:0]     pend_data, act_data;
  logic [N_DIGITS-1:0]          pend_dp, act_dp;
  logic [N_DIGITS-1:0]          pend_en, act_en;

  logic [6:0] glyph;
  logic       lit;

  assign sub_term  = (sub == SW'(STEP - 1));
  assign slot_term = sub_term && (phase == 4'd15);
  assign frame_bnd = slot_term && (digit_idx == IW'(N_DIGITS - 1));

  assign frame_done = frame_bnd;
  assign load_ack   = frame_bnd && pending;

  // Prescaler: sub counts within a phase step, phase counts 0..15 per slot
  always_ff @(posedge clk) begin
    if (reset) begin
      sub   <= '0;
      phase <= '0;
    end else if (sub_term) begin
      sub   <= '0;
      phase <= phase + 4'd1;
    end else begin
      sub <= sub + SW'(1);
    end
  end

  // Digit scan index, advances on each slot terminal
  always_ff @(posedge clk) begin
    if (reset)
      digit_idx <= '0;
    else if (slot_term)
      digit_idx <= (digit_idx == IW'(N_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
  end

  // Double buffer: load fills pending, frame boundary promotes it to active.
  // A load on the boundary cycle lands in pending after the old value moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      act_en    <= '0;
    end else begin
      if (frame_bnd && pending) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        act_en   <= pend_en;
        pending  <= 1'b0;
      end
      if (load) begin
        pend_data <= data;
        pend_dp   <= dp;
        pend_en   <= digit_en;
        pending   <= 1'b1;
      end
    end
  end

  hex_to_seg u_dec (
    .nib (act_data[digit_idx]),
    .seg (glyph)
  );

  assign lit = act_en[digit_idx] && (phase <= brightness);

  // Registered drivers; segments are blanked whenever the anode is off
  always_ff @(posedge clk) begin
    if (reset) begin
      anode <= '1;
      seg   <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else if (lit) begin
      anode <= ~(N_DIGITS'(1) << digit_idx);
      seg   <= glyph;
      dp_n  <= ~act_dp[digit_idx];
    end else begin
      anode <= '1;
      seg   <= SEG_BLANK;
      dp_n  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at N_DIGITS=4, REFRESH_DIV=16
// (one slot = 16 cycles, one frame = 64 cycles).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  brightness = '0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        load_ack;

  int checks = 0;
  int failures = 0;
  int t = 0;  // cycles since reset release

  seg_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .digit_en   (digit_en),
    .brightness (brightness),
    .anode      (anode),
    .seg        (seg),
    .dp_n       (dp_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done),
    .load_ack   (load_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load  = 1'b1;  // must be ignored under reset
    data  = 16'hFFFF; digit_en = 4'hF;
    tick(); tick();
    load = 1'b0;
    checks++;
    if (anode !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || digit_idx !== 2'd0 ||
        frame_done !== 1'b0 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: anode=%h seg=%h dp_n=%b idx=%0d fd=%b ack=%b, need F 7f 1 0 0 0",
               anode, seg, dp_n, digit_idx, frame_done, load_ack);
    end
    reset = 1'b0;
    t = 0;
  endtask

  // No load: dark for 200 cycles, frame_done every 64
  task automatic test_blank();
    while (t < 200) begin
      checks++;
      if (anode !== 4'hF || seg !== 7'h7F) begin
        failures++;
        $display("FAIL blank t=%0d: anode=%h seg=%h, need F 7f", t, anode, seg);
      end
      checks++;
      if (frame_done !== ((t % 64) == 63)) begin
        failures++;
        $display("FAIL frame_done t=%0d: got %b need %b", t, frame_done, (t % 64) == 63);
      end
      checks++;
      if (load_ack !== 1'b0) begin
        failures++;
        $display("FAIL blank_ack t=%0d: got %b need 0", t, load_ack);
      end
      tick();
    end
  endtask

  // 1234 loaded at t=0, becomes active at boundary t=63
  task automatic test_load();
    brightness = 4'd15;
    while (t < 128) begin
      if (t == 0) begin
        load = 1'b1; data = 16'h1234; dp = 4'b0001; digit_en = 4'hF;
      end else begin
        load = 1'b0;
      end
      checks++;
      if (load_ack !== (t == 63)) begin
        failures++;
        $display("FAIL load_ack t=%0d: got %b need %b", t, load_ack, t == 63);
      end
      if (t == 64) begin
        checks++;
        if (digit_idx !== 2'd0 || anode !== 4'hF) begin
          failures++;
          $display("FAIL wrap t=64: idx=%0d anode=%h, need 0 F", digit_idx, anode);
        end
      end
      if (t == 65) begin
        checks++;
        if (anode !== 4'b1110 || seg !== 7'h19 || dp_n !== 1'b0) begin
          failures++;
          $display("FAIL digit0 t=65: anode=%b seg=%h dp_n=%b, need 1110 19 0", anode, seg, dp_n);
        end
      end
      if (t == 112) begin
        checks++;
        if (digit_idx !== 2'd3) begin
          failures++;
          $display("FAIL idx t=112: got %0d need 3", digit_idx);
        end
      end
      if (t == 113) begin
        checks++;
        if (anode !== 4'b0111 || seg !== 7'h79 || dp_n !== 1'b1) begin
          failures++;
          $display("FAIL digit3 t=113: anode=%b seg=%h dp_n=%b, need 0111 79 1", anode, seg, dp_n);
        end
      end
      tick();
    end
  endtask

  // Continues from t=128 (digit 0, phase 0): brightness 3 -> 4 of 16 lit
  task automatic test_brightness();
    int lit_cnt;
    logic exp_lit;
    lit_cnt = 0;
    brightness = 4'd3;
    tick();
    while (t <= 144) begin
      exp_lit = (t <= 132);
      if (anode !== 4'hF) lit_cnt++;
      checks++;
      if (anode !== (exp_lit ? 4'b1110 : 4'hF) || seg !== (exp_lit ? 7'h19 : 7'h7F)) begin
        failures++;
        $display("FAIL bright t=%0d: anode=%b seg=%h, need %b %h", t, anode, seg,
                 exp_lit ? 4'b1110 : 4'hF, exp_lit ? 7'h19 : 7'h7F);
      end
      tick();
    end
    checks++;
    if (lit_cnt != 4) begin
      failures++;
      $display("FAIL bright_count: got %0d need 4", lit_cnt);
    end
  endtask

  // AAAA then 5555 before the boundary: one ack, only 5 ever shown
  task automatic test_last_wins();
    int acks;
    acks = 0;
    brightness = 4'd15;
    while (t <= 140) begin
      load = 1'b0;
      if (t == 10) begin load = 1'b1; data = 16'hAAAA; dp = 4'h0; digit_en = 4'hF; end
      if (t == 30) begin load = 1'b1; data = 16'h5555; end
      if (load_ack === 1'b1) acks++;
      checks++;
      if (seg !== ((t >= 65) ? 7'h12 : 7'h7F)) begin
        failures++;
        $display("FAIL last_wins seg t=%0d: got %h need %h", t, seg, (t >= 65) ? 7'h12 : 7'h7F);
      end
      tick();
    end
    load = 1'b0;
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL last_wins acks: got %0d need 1", acks);
    end
  endtask

  // Load on the boundary cycle with nothing pending: ack one frame later
  task automatic test_load_on_boundary();
    while (t <= 130) begin
      load = 1'b0;
      if (t == 63) begin load = 1'b1; data = 16'h0007; digit_en = 4'h1; end
      checks++;
      if (load_ack !== (t == 127)) begin
        failures++;
        $display("FAIL boundary_ack t=%0d: got %b need %b", t, load_ack, t == 127);
      end
      if (t == 63) begin
        checks++;
        if (frame_done !== 1'b1) begin
          failures++;
          $display("FAIL boundary_fd t=63: got %b need 1", frame_done);
        end
      end
      tick();
    end
    load = 1'b0;
  endtask

  // Reset at digit 2 with pending set: blank, no ack, scan restarts at 0
  task automatic test_reset_mid();
    brightness = 4'd15;
    while (t < 100) begin
      load = 1'b0;
      if (t == 0)  begin load = 1'b1; data = 16'h1234; digit_en = 4'hF; dp = 4'h0; end
      if (t == 70) begin load = 1'b1; data = 16'h9999; end
      tick();
    end
    load = 1'b0;
    checks++;
    if (digit_idx !== 2'd2 || anode !== 4'b1011 || seg !== 7'h24) begin
      failures++;
      $display("FAIL pre_reset t=100: idx=%0d anode=%b seg=%h, need 2 1011 24", digit_idx, anode, seg);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (anode !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset: anode=%b seg=%h dp_n=%b idx=%0d, need 1111 7f 1 0", anode, seg, dp_n, digit_idx);
    end
    reset = 1'b0;
    t = 0;
    while (t <= 130) begin
      checks++;
      if (load_ack !== 1'b0 || anode !== 4'hF) begin
        failures++;
        $display("FAIL post_reset t=%0d: ack=%b anode=%b, need 0 1111", t, load_ack, anode);
      end
      if (t == 0 || t == 16) begin
        checks++;
        if (digit_idx !== ((t == 0) ? 2'd0 : 2'd1)) begin
          failures++;
          $display("FAIL restart_idx t=%0d: got %0d need %0d", t, digit_idx, (t == 0) ? 0 : 1);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_blank();
    test_reset();
    test_load();
    test_brightness();
    test_reset();
    test_last_wins();
    test_reset();
    test_load_on_boundary();
    test_reset();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot; must be a multiple of 16 and at least 16.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port load, input, 1: single-cycle strobe that captures data, dp and digit_en.
REQ-006 SHALL have port data, input, 4*N_DIGITS: hex nibble per digit; digit 0 is the rightmost, at bits [3:0].
REQ-007 SHALL have port dp, input, N_DIGITS: decimal point per digit, 1 = lit.
REQ-008 SHALL have port digit_en, input, N_DIGITS: per-digit enable, 1 = shown.
REQ-009 SHALL have port brightness, input, 4: duty level, sampled live.
REQ-010 SHALL have port anode, output, N_DIGITS: active-low digit selects.
REQ-011 SHALL have port seg, output, 7: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dp_n, output, 1: active-low decimal point.
REQ-013 SHALL have port digit_idx, output, clog2(N_DIGITS): index of the digit currently scanned.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse on each wrap of the scan.
REQ-015 SHALL have port load_ack, output, 1: one-cycle pulse when pending data becomes active.

Function
REQ-016 SHALL run a prescaler that counts 0..REFRESH_DIV-1 and wraps to 0; the cycle at REFRESH_DIV-1 is the slot terminal.
REQ-017 SHALL advance digit_idx by one at each slot terminal, wrapping from N_DIGITS-1 to 0.
REQ-018 SHALL treat the terminal of the slot with digit_idx = N_DIGITS-1 as the frame boundary and SHALL pulse frame_done in that cycle.
REQ-019 SHALL define phase as prescaler / (REFRESH_DIV/16), giving values 0..15.
REQ-020 SHALL drive the selected anode low only while phase <= brightness; brightness 0 gives 1/16 duty and brightness 15 gives full duty.
REQ-021 SHALL drive exactly one anode bit low when lit, and all anode bits high otherwise.
REQ-022 SHALL keep a digit dark (anode, seg and dp_n all high) when its active digit_en bit is 0.
REQ-023 SHALL decode nibble values 0..F to standard hex glyphs, including lowercase b and d.
REQ-024 SHALL register anode, seg and dp_n, giving exactly one cycle of latency from a digit_idx or phase change to the outputs.
REQ-025 SHALL drive seg and dp_n all high whenever the anode is off, to prevent ghosting.
REQ-026 SHALL, on load, copy data, dp and digit_en into pending registers and set the pending flag.
REQ-027 SHALL, when load repeats while pending is set, overwrite the pending registers (last load wins).
REQ-028 SHALL, at a frame boundary with pending set, copy pending to the active registers, clear pending and pulse load_ack in the same cycle.
REQ-029 SHALL keep active data unchanged mid-frame; no tearing is permitted.
REQ-030 SHALL, when load coincides with a frame boundary, transfer the old pending value (if any) and capture the new load as pending, to be applied at the next boundary.
REQ-031 SHALL, for brightness changes mid-slot, take effect from the next cycle's phase compare.

Reset
REQ-032 SHALL, on reset, force prescaler=0, digit_idx=0, pending=0, active data/dp/digit_en=0, anode all 1s, seg=7'h7F, dp_n=1, frame_done=0, load_ack=0.
REQ-033 SHALL, on reset mid-frame, discard pending data and restart the scan at digit 0 on the first cycle after reset deasserts.
REQ-034 SHALL ignore load in any cycle where reset is asserted.

Structure
REQ-035 SHALL place the segment glyph constants and the active-low blank constant (7'h7F) in a shared package.
REQ-036 SHALL implement the nibble-to-segment decode as a combinational sub-module named hex_to_seg.
REQ-037 SHALL derive all widths from parameters; no literal widths tied to 8 digits are permitted.

Verification (N_DIGITS=4, REFRESH_DIV=16 unless stated)
REQ-038 Reset then no load -> anode=4'b1111, seg=7'h7F for 200 cycles; frame_done pulses every 64 cycles.
REQ-039 load data=16'h1234, digit_en=4'hF, brightness=15 -> load_ack at the first frame boundary; digit 0 shows glyph 4 with anode=4'b1110, then digit 3 shows glyph 1 with anode=4'b0111.
REQ-040 brightness=3 -> each anode low for exactly 4 of every 16 slot cycles, with seg=7'h7F in the other 12.
REQ-041 load 16'hAAAA mid-frame, then load 16'h5555 before the boundary -> a single load_ack; 5 is displayed and A never appears.
REQ-042 load asserted on the frame-boundary cycle with nothing pending -> no load_ack at that boundary; load_ack one frame (64 cycles) later.
REQ-043 reset asserted at digit_idx=2 with pending set -> outputs blank next cycle; after release, no load_ack occurs and the scan restarts at digit 0.
